// File: rtl/vga_hvsync_generator.sv
// -----------------------------------------------------------------------------
// vga_hvsync_generator
//   Free-running VGA timing generator (640x480@60Hz by default). Emits the
//   current pixel coordinates, an active-video flag and active-low HSYNC/VSYNC
//   for the downstream pixel pipeline. One pixel per clk, no handshake.
//
// Ports
//   clk          in   1   pixel clock, rising edge
//   rst_n        in   1   synchronous active-low reset
//   hsync        out  1   horizontal sync, active low, registered
//   vsync        out  1   vertical sync, active low, registered
//   display_on   out  1   (hpos,vpos) is inside the visible area
//   hpos         out  10  current column, 0..H_TOTAL-1
//   vpos         out  10  current line, 0..V_TOTAL-1
//   frame_start  out  1   one-clk pulse at (0,0) after a frame wrap
//                         (present only when VGA_FRAME_PULSE_EN is defined)
//
// Optional feature macro: VGA_FRAME_PULSE_EN
// Both H_TOTAL and V_TOTAL must be <= 1024 (10-bit counters).
// -----------------------------------------------------------------------------
module vga_hvsync_generator #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_BOTTOM  = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_TOP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
`ifdef VGA_FRAME_PULSE_EN
  output logic [9:0] vpos,
  output logic       frame_start
`else
  output logic [9:0] vpos
`endif
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_BOTTOM);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       h_wrap;

  // Next-state counters; syncs are decoded from the next state so they move
  // on the same edge as the counters instead of lagging by one clk.
  always_comb begin
    h_wrap  = (hpos_q == H_MAX);
    hpos_d  = h_wrap ? 10'd0 : hpos_q + 10'd1;
    vpos_d  = vpos_q;
    if (h_wrap) vpos_d = (vpos_q == V_MAX) ? 10'd0 : vpos_q + 10'd1;
    hsync_d = !((hpos_d >= HS_FIRST) && (hpos_d <= HS_LAST));
    vsync_d = !((vpos_d >= VS_FIRST) && (vpos_d <= VS_LAST));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos_q  <= 10'd0;
      vpos_q  <= 10'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

`ifdef VGA_FRAME_PULSE_EN
  // High only when the counters land on (0,0) through a frame wrap, so the
  // (0,0) that directly follows reset does not pulse.
  logic frame_start_q, frame_start_d;

  always_comb frame_start_d = h_wrap && (vpos_q == V_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) frame_start_q <= 1'b0;
    else        frame_start_q <= frame_start_d;
  end

  assign frame_start = frame_start_q;
`endif

  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// -----------------------------------------------------------------------------
// tb_vga_hvsync_generator
//   Instance D uses the default 640x480 timing for reset and line checks.
//   Instance S uses a scaled-down timing (15 x 13 = 195 clks per frame) so
//   frame-level behaviour fits in a short run:
//     H: display 8, front 2, sync 3, back 2  -> hsync low at hpos 10..12
//     V: display 6, bottom 2, sync 2, top 3  -> vsync low at vpos 8..9
// -----------------------------------------------------------------------------
module tb_vga_hvsync_generator;

  logic       clk = 1'b0;
  logic       rst_n, rst_s_n;
  logic       hs_d, vs_d, disp_d, hs_s, vs_s, disp_s;
  logic [9:0] hp_d, vp_d, hp_s, vp_s;
`ifdef VGA_FRAME_PULSE_EN
  logic       fs_d, fs_s;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vga_hvsync_generator dut_d (
    .clk(clk), .rst_n(rst_n),
    .hsync(hs_d), .vsync(vs_d), .display_on(disp_d),
    .hpos(hp_d),
`ifdef VGA_FRAME_PULSE_EN
    .vpos(vp_d), .frame_start(fs_d)
`else
    .vpos(vp_d)
`endif
  );

  vga_hvsync_generator #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(3)
  ) dut_s (
    .clk(clk), .rst_n(rst_s_n),
    .hsync(hs_s), .vsync(vs_s), .display_on(disp_s),
    .hpos(hp_s),
`ifdef VGA_FRAME_PULSE_EN
    .vpos(vp_s), .frame_start(fs_s)
`else
    .vpos(vp_s)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clk and settle past the edge before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs_cnt, hs_first, hs_last, disp_cnt;
    int vs_cnt, vs_first, vs_last, disp_bad, fs_cnt, fs_bad, fs_first;

    // ---------------- reset ----------------
    rst_n   = 1'b0;
    rst_s_n = 1'b0;
    repeat (3) step();
    chk("rst_hpos", hp_d, 0);
    chk("rst_vpos", vp_d, 0);
    chk("rst_hsync", hs_d, 1);
    chk("rst_vsync", vs_d, 1);
    chk("rst_disp", disp_d, 1);
    chk("rst_s_hpos", hp_s, 0);
    chk("rst_s_vpos", vp_s, 0);
`ifdef VGA_FRAME_PULSE_EN
    chk("rst_fs", fs_d, 0);
`endif

    // ---------------- line timing (default instance) ----------------
    rst_n = 1'b1;
`ifdef VGA_FRAME_PULSE_EN
    chk("fs_first_cycle", fs_d, 0);
`endif
    hs_cnt = 0; hs_first = -1; hs_last = -1; disp_cnt = 0;
    for (int c = 1; c <= 1600; c++) begin
      step();
      if (c <= 800) begin
        if (!hs_d) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(hp_d);
          hs_last = int'(hp_d);
        end
        if (disp_d) disp_cnt++;
      end
      if (c == 1)    chk("line_hpos1", hp_d, 1);
      if (c == 639)  chk("line_disp639", disp_d, 1);
      if (c == 640) begin
        chk("line_disp640", disp_d, 0);
        chk("line_hpos640", hp_d, 640);
      end
      if (c == 799) begin
        chk("line_hpos799", hp_d, 799);
        chk("line_vpos799", vp_d, 0);
      end
      if (c == 800) begin
        chk("wrap_hpos", hp_d, 0);
        chk("wrap_vpos", vp_d, 1);
        chk("wrap_hsync", hs_d, 1);
      end
      if (c == 1600) begin
        chk("line2_hpos", hp_d, 0);
        chk("line2_vpos", vp_d, 2);
      end
    end
    chk("hsync_low_cnt", hs_cnt, 96);
    chk("hsync_first", hs_first, 656);
    chk("hsync_last", hs_last, 751);
    chk("line_disp_cnt", disp_cnt, 640);
    chk("vsync_line0", vs_d, 1);

    // ---------------- frame timing (scaled instance) ----------------
    rst_s_n = 1'b1;
    vs_cnt = 0; vs_first = -1; vs_last = -1; disp_cnt = 0; disp_bad = 0;
    fs_cnt = 0; fs_bad = 0; fs_first = -1; hs_cnt = 0;
    for (int c = 1; c <= 390; c++) begin
      step();
      if (c <= 195) begin
        if (!vs_s) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = c;
          vs_last = c;
        end
        if (disp_s) disp_cnt++;
      end
      if (c <= 15 && !hs_s) hs_cnt++;
      if (disp_s && vp_s >= 10'd6) disp_bad++;
`ifdef VGA_FRAME_PULSE_EN
      if (fs_s) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = c;
        if (hp_s != 10'd0 || vp_s != 10'd0) fs_bad++;
      end
`endif
      if (c == 120) chk("s_vs_start_vpos", vp_s, 8);
      if (c == 194) begin
        chk("s_end_hpos", hp_s, 14);
        chk("s_end_vpos", vp_s, 12);
      end
      if (c == 195) begin
        chk("s_wrap_hpos", hp_s, 0);
        chk("s_wrap_vpos", vp_s, 0);
        chk("s_wrap_vsync", vs_s, 1);
        chk("s_wrap_disp", disp_s, 1);
      end
    end
    chk("s_hsync_cnt", hs_cnt, 3);
    chk("s_vsync_cnt", vs_cnt, 30);
    chk("s_vsync_first", vs_first, 120);
    chk("s_vsync_last", vs_last, 149);
    chk("s_active_cnt", disp_cnt, 48);
    chk("s_disp_blank", disp_bad, 0);
`ifdef VGA_FRAME_PULSE_EN
    chk("s_fs_cnt", fs_cnt, 2);
    chk("s_fs_pos", fs_bad, 0);
    chk("s_fs_first", fs_first, 195);
`endif

    // ---------------- mid-frame reset at (11,9): in hsync and vsync ----------
    rst_s_n = 1'b0;
    step();
    rst_s_n = 1'b1;
    repeat (146) step();
    chk("mid_pre_hpos", hp_s, 11);
    chk("mid_pre_vpos", vp_s, 9);
    chk("mid_pre_hsync", hs_s, 0);
    chk("mid_pre_vsync", vs_s, 0);
    rst_s_n = 1'b0;
    step();
    chk("mid_hpos", hp_s, 0);
    chk("mid_vpos", vp_s, 0);
    chk("mid_hsync", hs_s, 1);
    chk("mid_vsync", vs_s, 1);
    chk("mid_disp", disp_s, 1);
`ifdef VGA_FRAME_PULSE_EN
    chk("mid_fs", fs_s, 0);
`endif
    rst_s_n = 1'b1;
    step();
    chk("mid_resume_hpos", hp_s, 1);
    chk("mid_resume_vpos", vp_s, 0);
    repeat (14) step();
    chk("mid_line_hpos", hp_s, 0);
    chk("mid_line_vpos", vp_s, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
